gelato_l2_cache_responder: RTL and testbench

L2-side responder for the L1↔L2 line-refill channel. It accepts an L1 line request (`valid`/`addr`) and looks it up in a direct-mapped L2 tag/data store. A hit returns the line with a one-cycle `done` pulse. A miss first fetches the line from memory as a multi-beat burst, installs it, then responds. It sits between the L1 caches and the memory port.

---
 rtl/gelato_l2_cache_responder_if.sv | 36 +++
 rtl/gelato_l2_cache_responder.sv | 161 ++++++++++++++++
 tb/tb_gelato_l2_cache_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/gelato_l2_cache_responder_if.sv
// gelato_l2_cache_responder_if
// Bundles the L1 line-request channel and the memory burst channel that the
// L2 responder sits between.
//   valid/addr            : L1 request, held until done is seen
//   done/data             : one-cycle response pulse and returned line
//   mem_req_valid/ready   : burst read request handshake
//   mem_req_addr          : line-aligned burst address
//   mem_rsp_valid/data    : burst beats, beat 0 first, no backpressure
// Modports:
//   master : the side that issues L1 requests and plays memory (e.g. a bench)
//   slave  : the responder itself
interface gelato_l2_cache_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WORDS = 16
);
  logic                             valid;
  logic [ADDR_WIDTH-1:0]            addr;
  logic                             done;
  logic [LINE_WORDS*WORD_WIDTH-1:0] data;
  logic                             mem_req_valid;
  logic                             mem_req_ready;
  logic [ADDR_WIDTH-1:0]            mem_req_addr;
  logic                             mem_rsp_valid;
  logic [WORD_WIDTH-1:0]            mem_rsp_data;

  modport master (
    output valid, addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  done, data, mem_req_valid, mem_req_addr
  );

  modport slave (
    input  valid, addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output done, data, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/gelato_l2_cache_responder.sv
// gelato_l2_cache_responder
// L2-side responder for the L1<->L2 line-refill channel. A request is looked
// up in a direct-mapped tag/data store; a hit returns the stored line, a miss
// fetches the line from memory as a LINE_WORDS-beat burst, installs it and
// then returns it. Every response is a one-cycle done pulse with data held
// until the next response.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gelato_l2_cache_responder_if.slave (L1 request + memory burst)
//   stat_hits, stat_misses : saturating lookup counters, present only when
//                            GELATO_L2_RESPONDER_STATS_EN is defined
// Optional feature macro: GELATO_L2_RESPONDER_STATS_EN
module gelato_l2_cache_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WORDS = 16,
  parameter int SETS       = 64
) (
  input  logic clk,
  input  logic rst_n,
  gelato_l2_cache_responder_if.slave bus
`ifdef GELATO_L2_RESPONDER_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  localparam int LINE_BITS   = LINE_WORDS * WORD_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam int INDEX_BITS  = $clog2(SETS);
  localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
  localparam int CNT_BITS    = $clog2(LINE_WORDS);

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
  localparam logic [CNT_BITS-1:0]   LAST_BEAT   = CNT_BITS'(LINE_WORDS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_FILL_REQ  = 3'd2;
  localparam logic [2:0] S_FILL_WAIT = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [SETS-1:0]       set_valid;
  logic [TAG_BITS-1:0]   tag_mem  [SETS];
  logic [LINE_BITS-1:0]  data_mem [SETS];
  logic [LINE_BITS-1:0]  line_buf;
  logic [LINE_BITS-1:0]  fill_line;
  logic [CNT_BITS-1:0]   beat_cnt;
  logic                  done_q;
  logic [LINE_BITS-1:0]  data_q;
  logic                  mem_req_valid_q;
  logic [ADDR_WIDTH-1:0] mem_req_addr_q;

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit;
  logic                  last_beat;

  assign req_index = req_addr[OFFSET_BITS +: INDEX_BITS];
  assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign hit       = set_valid[req_index] && (tag_mem[req_index] == req_tag);
  assign last_beat = bus.mem_rsp_valid && (beat_cnt == LAST_BEAT);

  assign bus.done          = done_q;
  assign bus.data          = data_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;

  // Line buffer with the current beat merged in, so the final beat can be
  // installed in the same edge it arrives on.
  always_comb begin
    fill_line = line_buf;
    fill_line[beat_cnt*WORD_WIDTH +: WORD_WIDTH] = bus.mem_rsp_data;
  end

  // Tag and data arrays carry no reset; the per-set valid bits guard them.
  always_ff @(posedge clk) begin
    if (state == S_FILL_WAIT && last_beat) begin
      tag_mem[req_index]  <= req_tag;
      data_mem[req_index] <= fill_line;
    end
  end

  // Request FSM. IDLE ignores valid while done is high because L1 still holds
  // its finished request during the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      req_addr        <= '0;
      set_valid       <= '0;
      line_buf        <= '0;
      beat_cnt        <= '0;
      done_q          <= 1'b0;
      data_q          <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.valid && !done_q) begin
            req_addr <= bus.addr;
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            state <= S_RESP;
          end else begin
            mem_req_addr_q  <= req_addr & ~OFFSET_MASK;
            mem_req_valid_q <= 1'b1;
            state           <= S_FILL_REQ;
          end
        end
        S_FILL_REQ: begin
          if (mem_req_valid_q && bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            beat_cnt        <= '0;
            state           <= S_FILL_WAIT;
          end
        end
        S_FILL_WAIT: begin
          if (bus.mem_rsp_valid) begin
            line_buf <= fill_line;
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              set_valid[req_index] <= 1'b1;
              state                <= S_RESP;
            end
          end
        end
        S_RESP: begin
          data_q <= data_mem[req_index];
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GELATO_L2_RESPONDER_STATS_EN
  // One count per lookup outcome, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit) begin
        if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gelato_l2_cache_responder.sv
// tb_gelato_l2_cache_responder
// Directed and randomized requests against gelato_l2_cache_responder with a
// behavioural cache model (per-set valid/tag/line arrays indexed by address
// arithmetic). The bench plays both the L1 requester and the memory.
module tb_gelato_l2_cache_responder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bit          ref_valid [64];
  logic [31:0] ref_tag   [64];
  logic [31:0] ref_line  [64][16];
  int          exp_hits;
  int          exp_misses;

  gelato_l2_cache_responder_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .LINE_WORDS(16)) bus ();

`ifdef GELATO_L2_RESPONDER_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  gelato_l2_cache_responder #(
    .ADDR_WIDTH(32), .WORD_WIDTH(32), .LINE_WORDS(16), .SETS(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef GELATO_L2_RESPONDER_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a transaction loop ever stalls beyond its own bound.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < 64; s++) ref_valid[s] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // One L1 request. Memory is modelled here: request acceptance is held off
  // for ready_delay cycles of mem_req_valid, beats optionally arrive every
  // third cycle, and junk beats are driven whenever no fill is in progress.
  // abort_after > 0 returns early once that many beats have been clocked in.
  task automatic applyStimulus(input logic [31:0] a, input int ready_delay,
                               input bit gaps, input bit rand_beats,
                               input logic [31:0] base, input int abort_after);
    int          idx;
    logic [31:0] tg;
    bit          exp_hit;
    logic [31:0] words [16];
    logic [511:0] exp_line;
    int          cyc, req_seen, hs, beats, slot, done_cyc;
    bit          hs_done, finished, ready_lvl;

    idx     = int'((a >> 6) & 32'h3F);
    tg      = a >> 12;
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
    for (int i = 0; i < 16; i++) words[i] = rand_beats ? $urandom : base + i;
    cyc = 0; req_seen = 0; hs = 0; beats = 0; slot = 0; done_cyc = 0;
    hs_done = 1'b0; finished = 1'b0;

    @(negedge clk);
    bus.addr  = a;
    bus.valid = 1'b1;

    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (abort_after != 0 && beats == abort_after) begin
        if (!exp_hit) exp_misses++;
        return;
      end
      if (bus.mem_req_valid) begin
        req_seen++;
        checkOutput("mem_req_addr", bus.mem_req_addr, a & 32'hFFFF_FFC0);
      end
      if (bus.done) begin
        finished = 1'b1;
        done_cyc = cyc;
      end
      ready_lvl = (req_seen > ready_delay);
      if (bus.mem_req_valid && ready_lvl) hs++;
      bus.mem_req_ready = ready_lvl;
      bus.mem_rsp_valid = 1'b0;
      if (hs_done && beats < 16) begin
        if (!gaps || (slot % 3) == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = words[beats];
          beats++;
        end
        slot++;
      end else if (!hs_done) begin
        bus.mem_rsp_valid = 1'($urandom_range(0, 1));
        bus.mem_rsp_data  = $urandom;
      end
      if (bus.mem_req_valid && ready_lvl) hs_done = 1'b1;
    end

    if (exp_hit) begin
      for (int i = 0; i < 16; i++) exp_line[i*32 +: 32] = ref_line[idx][i];
      exp_hits++;
    end else begin
      for (int i = 0; i < 16; i++) begin
        exp_line[i*32 +: 32] = words[i];
        ref_line[idx][i]     = words[i];
      end
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
      exp_misses++;
    end

    checkOutput("done_seen", 512'(finished), 512'(1));
    checkOutput("line_data", bus.data, exp_line);
    checkOutput("handshakes", 512'(hs), exp_hit ? 512'(0) : 512'(1));
    checkOutput("req_valid_cycles", 512'(req_seen), exp_hit ? 512'(0) : 512'(ready_delay + 1));
    if (exp_hit)
      checkOutput("hit_latency", 512'(done_cyc), 512'(3));
    else
      checkOutput("miss_latency", 512'(done_cyc), 512'(3 + ready_delay + 1 + slot));
    if (!exp_hit) checkOutput("beats_before_done", 512'(beats), 512'(16));

    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    checkOutput("done_one_cycle", 512'(bus.done), 512'(0));
    checkOutput("data_held", bus.data, exp_line);
    bus.valid = 1'b0;
`ifdef GELATO_L2_RESPONDER_STATS_EN
    checkOutput("stat_hits", 512'(stat_hits), 512'(exp_hits));
    checkOutput("stat_misses", 512'(stat_misses), 512'(exp_misses));
`endif
  endtask

  initial begin
    int junk_done;
    int junk_req;
    logic [31:0] ra;

    checks = 0;
    errors = 0;
    modelReset();
    rst_n             = 1'b0;
    bus.valid         = 1'b0;
    bus.addr          = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_done", 512'(bus.done), 512'(0));
    checkOutput("reset_data", bus.data, 512'(0));
    checkOutput("reset_mem_req_valid", 512'(bus.mem_req_valid), 512'(0));
    checkOutput("reset_mem_req_addr", 512'(bus.mem_req_addr), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] cold miss 0x1044");
    applyStimulus(32'h0000_1044, 0, 1'b0, 1'b0, 32'h100, 0);
    $display("[TB] hit 0x107C");
    applyStimulus(32'h0000_107C, 0, 1'b0, 1'b0, 32'h0, 0);
    $display("[TB] conflict 0x2040 then 0x1040");
    applyStimulus(32'h0000_2040, 0, 1'b0, 1'b0, 32'h200, 0);
    applyStimulus(32'h0000_1040, 0, 1'b0, 1'b1, 32'h0, 0);
    $display("[TB] request backpressure");
    applyStimulus(32'h0000_5080, 5, 1'b0, 1'b1, 32'h0, 0);
    $display("[TB] beat gaps");
    applyStimulus(32'h0000_6100, 0, 1'b1, 1'b0, 32'h600, 0);
    applyStimulus(32'h0000_6104, 0, 1'b0, 1'b0, 32'h0, 0);

    $display("[TB] reset mid-fill");
    applyStimulus(32'h0000_3000, 0, 1'b0, 1'b1, 32'h0, 7);
    rst_n             = 1'b0;
    bus.valid         = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    modelReset();
    #1;
    checkOutput("midfill_done", 512'(bus.done), 512'(0));
    checkOutput("midfill_data", bus.data, 512'(0));
    checkOutput("midfill_mem_req_valid", 512'(bus.mem_req_valid), 512'(0));
    checkOutput("midfill_mem_req_addr", 512'(bus.mem_req_addr), 512'(0));
    junk_done = 0;
    junk_req  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      junk_done += int'(bus.done);
      junk_req  += int'(bus.mem_req_valid);
      bus.mem_rsp_valid = 1'($urandom_range(0, 1));
      bus.mem_rsp_data  = $urandom;
    end
    bus.mem_rsp_valid = 1'b0;
    checkOutput("no_done_after_reset", 512'(junk_done), 512'(0));
    checkOutput("no_req_after_reset", 512'(junk_req), 512'(0));
    applyStimulus(32'h0000_3000, 0, 1'b0, 1'b1, 32'h0, 0);
    applyStimulus(32'h0000_1040, 1, 1'b0, 1'b1, 32'h0, 0);

    $display("[TB] randomized requests");
    for (int n = 0; n < 24; n++) begin
      ra = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 6) | $urandom_range(0, 63);
      applyStimulus(ra, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, 32'h0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
